// File: rtl/key_volume_ctrl.sv
// Headphone-volume front end: turns debounced key pulses into WM8731 LHPOUT register
// writes over a req/ack handshake, coalescing presses that arrive while a write is pending.
module key_volume_ctrl #(
   parameter logic [6:0]  VOL_MIN   = 7'h30,
   parameter logic [6:0]  VOL_MAX   = 7'h7F,
   parameter logic [6:0]  VOL_DEF   = 7'h79,
   parameter int unsigned VOL_STEP  = 4,
   parameter logic [6:0]  MUTE_CODE = 7'h2F,
   parameter int unsigned TIMEOUT   = 1000
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic [2:0]  key_in,
   output logic        cfg_req,
   output logic [15:0] cfg_data,
   input  logic        cfg_ack,
   output logic [6:0]  vol_level,
   output logic        mute,
   output logic        cfg_err
);

   localparam int unsigned CNT_W    = $clog2(TIMEOUT);
   localparam logic [6:0]  CFG_ADDR = 7'h02;

   typedef enum logic {S_IDLE, S_REQ} state_t;

   state_t           state, state_nxt;
   logic             dirty, dirty_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             req_nxt, err_nxt, mute_nxt;
   logic [15:0]      data_nxt;
   logic [6:0]       vol_nxt;

   logic       key_mute_c, key_up_c, key_dn_c, key_evt_c;
   logic [7:0] up_sum_c, dn_diff_c, dn_floor_c;
   logic [6:0] vol_up_c, vol_dn_c, lhp_vol_c;
   logic [15:0] word_c;

   // Key decode: MUTE wins; UP and DOWN together cancel
   always_comb begin
      key_mute_c = key_in[2];
      key_up_c   = ~key_in[2] & key_in[0] & ~key_in[1];
      key_dn_c   = ~key_in[2] & key_in[1] & ~key_in[0];
      key_evt_c  = key_mute_c | key_up_c | key_dn_c;
   end

   // Saturating step arithmetic in 8 bits, clamped before narrowing
   always_comb begin
      up_sum_c   = {1'b0, vol_level} + 8'(VOL_STEP);
      dn_floor_c = {1'b0, VOL_MIN} + 8'(VOL_STEP);
      dn_diff_c  = {1'b0, vol_level} - 8'(VOL_STEP);
      vol_up_c   = (up_sum_c > {1'b0, VOL_MAX}) ? VOL_MAX : 7'(up_sum_c);
      vol_dn_c   = ({1'b0, vol_level} < dn_floor_c) ? VOL_MIN : 7'(dn_diff_c);
      lhp_vol_c  = mute ? MUTE_CODE : vol_level;
      word_c     = {CFG_ADDR, 1'b1, 1'b0, lhp_vol_c};
   end

   // Next-state and registered-output logic
   always_comb begin
      state_nxt = state;
      dirty_nxt = dirty;
      cnt_nxt   = cnt;
      req_nxt   = cfg_req;
      err_nxt   = cfg_err;
      data_nxt  = cfg_data;
      vol_nxt   = vol_level;
      mute_nxt  = mute;

      case (state)
         S_IDLE: begin
            if (dirty) begin
               data_nxt  = word_c;
               dirty_nxt = 1'b0;
               req_nxt   = 1'b1;
               cnt_nxt   = '0;
               state_nxt = S_REQ;
            end
         end
         S_REQ: begin
            if (cfg_ack) begin
               req_nxt   = 1'b0;
               err_nxt   = 1'b0;
               state_nxt = S_IDLE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
               req_nxt   = 1'b0;
               err_nxt   = 1'b1;
               dirty_nxt = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // A key event always leaves a fresh write pending, overriding any load above
      if (key_evt_c) begin
         dirty_nxt = 1'b1;
         if (key_mute_c) begin
            mute_nxt = ~mute;
         end else if (key_up_c) begin
            vol_nxt  = vol_up_c;
            mute_nxt = 1'b0;
         end else begin
            vol_nxt  = vol_dn_c;
            mute_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         state     <= S_IDLE;
         dirty     <= 1'b1;
         cnt       <= '0;
         cfg_req   <= 1'b0;
         cfg_err   <= 1'b0;
         cfg_data  <= 16'h0000;
         vol_level <= VOL_DEF;
         mute      <= 1'b0;
      end else begin
         state     <= state_nxt;
         dirty     <= dirty_nxt;
         cnt       <= cnt_nxt;
         cfg_req   <= req_nxt;
         cfg_err   <= err_nxt;
         cfg_data  <= data_nxt;
         vol_level <= vol_nxt;
         mute      <= mute_nxt;
      end
   end

endmodule

// File: tb/tb_key_volume_ctrl.sv
// Directed bench for key_volume_ctrl: reset write, stepping, mute, coalescing,
// saturation and ack timeout, with hand-computed register words.
module tb_key_volume_ctrl;

   localparam int unsigned TO = 20;

   logic        clk_in = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  key_in = 3'b000;
   logic        cfg_ack = 1'b0;
   logic        cfg_req;
   logic [15:0] cfg_data;
   logic [6:0]  vol_level;
   logic        mute;
   logic        cfg_err;

   int checks = 0;
   int errors = 0;

   key_volume_ctrl #(.TIMEOUT(TO)) dut (
      .clk_in   (clk_in),
      .rst      (rst),
      .key_in   (key_in),
      .cfg_req  (cfg_req),
      .cfg_data (cfg_data),
      .cfg_ack  (cfg_ack),
      .vol_level(vol_level),
      .mute     (mute),
      .cfg_err  (cfg_err)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic pulse_key(input logic [2:0] k);
      key_in = k;
      tick();
      key_in = 3'b000;
   endtask

   task automatic wait_req(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         if (cfg_req) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (cfg_req) ok = 1'b1;
   endtask

   task automatic ack_after(input int d);
      repeat (d) tick();
      cfg_ack = 1'b1;
      tick();
      cfg_ack = 1'b0;
   endtask

   task automatic quiet_cycles(input int n, output bit saw_req);
      saw_req = 1'b0;
      for (int i = 0; i < n; i++) begin
         tick();
         if (cfg_req) saw_req = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (4) tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      bit ok, saw;
      do_reset();
      checks++;
      if ({cfg_req, cfg_data, vol_level, mute, cfg_err} !== {1'b0, 16'h0000, 7'h79, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: req=%b data=%h vol=%h mute=%b err=%b, required 0 0000 79 0 0",
                  cfg_req, cfg_data, vol_level, mute, cfg_err);
      end
      wait_req(5, ok);
      checks++;
      if (!ok || cfg_data !== 16'h0579) begin
         errors++;
         $display("FAIL reset_write: req_seen=%b data=%h, required 1 0579", ok, cfg_data);
      end
      ack_after(2);
      checks++;
      if (cfg_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_ack_drop: req=%b, required 0", cfg_req);
      end
      // A stray ack while idle must do nothing
      cfg_ack = 1'b1;
      tick();
      cfg_ack = 1'b0;
      quiet_cycles(10, saw);
      checks++;
      if (saw || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_more_req: saw_req=%b err=%b, required 0 0", saw, cfg_err);
      end
   endtask

   task automatic test_volume_up();
      bit saw;
      logic [15:0] exp_w [3] = '{16'h057D, 16'h057F, 16'h057F};
      for (int i = 0; i < 3; i++) begin
         pulse_key(3'b001);
         checks++;
         if (cfg_req !== 1'b0) begin
            errors++;
            $display("FAIL up%0d_req_early: req=%b, required 0", i, cfg_req);
         end
         tick();
         checks++;
         if (cfg_req !== 1'b1 || cfg_data !== exp_w[i]) begin
            errors++;
            $display("FAIL up%0d_word: req=%b data=%h, required 1 %h", i, cfg_req, cfg_data, exp_w[i]);
         end
         ack_after(2);
         quiet_cycles(16, saw);
         checks++;
         if (saw || cfg_req !== 1'b0) begin
            errors++;
            $display("FAIL up%0d_single_write: saw_req=%b, required 0", i, saw);
         end
      end
      checks++;
      if (vol_level !== 7'h7F) begin
         errors++;
         $display("FAIL up_vol_max: vol=%h, required 7f", vol_level);
      end
   endtask

   task automatic test_mute();
      bit ok;
      do_reset();
      wait_req(5, ok);
      ack_after(1);
      pulse_key(3'b100);
      tick();
      checks++;
      if (cfg_req !== 1'b1 || cfg_data !== 16'h052F || mute !== 1'b1 || vol_level !== 7'h79) begin
         errors++;
         $display("FAIL mute_on: req=%b data=%h mute=%b vol=%h, required 1 052f 1 79",
                  cfg_req, cfg_data, mute, vol_level);
      end
      ack_after(1);
      pulse_key(3'b010);
      tick();
      checks++;
      if (cfg_req !== 1'b1 || cfg_data !== 16'h0575 || mute !== 1'b0 || vol_level !== 7'h75) begin
         errors++;
         $display("FAIL mute_down_unmute: req=%b data=%h mute=%b vol=%h, required 1 0575 0 75",
                  cfg_req, cfg_data, mute, vol_level);
      end
      ack_after(1);
   endtask

   task automatic test_coalesce();
      bit ok, saw;
      do_reset();
      wait_req(5, ok);
      // Reset write held un-acked while three keys arrive; 0x79+4 -> 0x7D, +4 clamps at 0x7F, -4 -> 0x7B
      pulse_key(3'b001);
      tick();
      pulse_key(3'b001);
      tick();
      pulse_key(3'b010);
      checks++;
      if (cfg_req !== 1'b1 || cfg_data !== 16'h0579) begin
         errors++;
         $display("FAIL coalesce_frozen: req=%b data=%h, required 1 0579", cfg_req, cfg_data);
      end
      ack_after(1);
      checks++;
      if (cfg_req !== 1'b0) begin
         errors++;
         $display("FAIL coalesce_gap: req=%b, required 0", cfg_req);
      end
      tick();
      checks++;
      if (cfg_req !== 1'b1 || cfg_data !== 16'h057B) begin
         errors++;
         $display("FAIL coalesce_word: req=%b data=%h, required 1 057b", cfg_req, cfg_data);
      end
      ack_after(1);
      quiet_cycles(10, saw);
      checks++;
      if (saw) begin
         errors++;
         $display("FAIL coalesce_extra_write: saw_req=%b, required 0", saw);
      end
   endtask

   task automatic test_noop_and_floor();
      bit ok, saw;
      pulse_key(3'b011);
      quiet_cycles(6, saw);
      checks++;
      if (saw || vol_level !== 7'h7B || mute !== 1'b0) begin
         errors++;
         $display("FAIL updown_noop: saw_req=%b vol=%h mute=%b, required 0 7b 0", saw, vol_level, mute);
      end
      for (int i = 0; i < 20; i++) begin
         pulse_key(3'b010);
         wait_req(4, ok);
         ack_after(1);
      end
      checks++;
      if (vol_level !== 7'h30) begin
         errors++;
         $display("FAIL floor_vol: vol=%h, required 30", vol_level);
      end
      pulse_key(3'b010);
      tick();
      checks++;
      if (cfg_req !== 1'b1 || cfg_data !== 16'h0530) begin
         errors++;
         $display("FAIL floor_word: req=%b data=%h, required 1 0530", cfg_req, cfg_data);
      end
      ack_after(1);
   endtask

   task automatic test_timeout();
      int high;
      pulse_key(3'b001);
      tick();
      high = 0;
      while (cfg_req === 1'b1 && high < 3 * TO) begin
         high++;
         tick();
      end
      checks++;
      if (high != TO || cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_len: req_high=%0d err=%b, required %0d 1", high, cfg_err, TO);
      end
      tick();
      checks++;
      if (cfg_req !== 1'b1 || cfg_data !== 16'h0534 || cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_retry: req=%b data=%h err=%b, required 1 0534 1", cfg_req, cfg_data, cfg_err);
      end
      ack_after(1);
      checks++;
      if (cfg_req !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_ack_clear: req=%b err=%b, required 0 0", cfg_req, cfg_err);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      pulse_key(3'b001);
      tick();
      rst = 1'b1;
      tick();
      checks++;
      if (cfg_req !== 1'b0 || vol_level !== 7'h79 || cfg_data !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid_drop: req=%b vol=%h data=%h, required 0 79 0000", cfg_req, vol_level, cfg_data);
      end
      rst = 1'b0;
      wait_req(5, ok);
      checks++;
      if (!ok || cfg_data !== 16'h0579) begin
         errors++;
         $display("FAIL reset_mid_rewrite: req_seen=%b data=%h, required 1 0579", ok, cfg_data);
      end
      ack_after(1);
   endtask

   initial begin
      test_reset();
      test_volume_up();
      test_mute();
      test_coalesce();
      test_noop_and_floor();
      test_timeout();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
